// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------------------------
// spi_pkg: shared definitions for the SPI mode-0 master.
//   - spi_state_e    : frame-sequencing FSM states
//   - SPI_CPOL/CPHA  : clock polarity / phase implemented by the master (mode 0)
//   - SPI_DATA_WIDTH : default frame width in bits
// ---------------------------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StTail,
        StHold
    } spi_state_e;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int unsigned SPI_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_master_if.sv
// ---------------------------------------------------------------------------------------------
// spi_master_if: user handshake plus SPI pin bundle for spi_master.
//   User side : data_in, data_in_valid, keep_cs (to master); data_out, data_out_valid, busy
//   SPI pins  : sck, cs (active low), mosi (from master); miso (to master)
// Modports:
//   master : the spi_master core
//   slave  : the user logic / peripheral side (drives requests and miso)
// ---------------------------------------------------------------------------------------------
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  keep_cs;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  busy;
    logic                  sck;
    logic                  cs;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  data_in, data_in_valid, keep_cs, miso,
        output data_out, data_out_valid, busy, sck, cs, mosi
    );

    modport slave (
        output data_in, data_in_valid, keep_cs, miso,
        input  data_out, data_out_valid, busy, sck, cs, mosi
    );

endinterface

// File: rtl/spi_sck_divider.sv
// ---------------------------------------------------------------------------------------------
// spi_sck_divider: half-period timer for the SPI clock.
//   clk, rst    : system clock, asynchronous active-high reset
//   i_restart   : clears the count (asserted by the FSM on every state change)
//   o_tick      : high in the last clk cycle of each CLK_DIV-cycle half period
// ---------------------------------------------------------------------------------------------
module spi_sck_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    // Keep at least one counter bit so CLK_DIV=1 still elaborates; the count then stays 0.
    localparam int unsigned      CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0]  CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] r_cnt;

    assign o_tick = (r_cnt == CntMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------------------------
// spi_master: single-clock SPI mode-0 master, one DATA_WIDTH-bit frame (MSB first) per request.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : spi_master_if.master
//              data_in/data_in_valid/keep_cs : request, accepted only in IDLE or HOLD
//              data_out/data_out_valid       : received word and its one-cycle strobe
//              busy                          : acceptance until frame completion
//              sck/cs/mosi/miso              : SPI pins (sck idles low, cs active low)
// Parameters: CLK_DIV = sck half-period in clk cycles (>=1), DATA_WIDTH = bits per frame (>=2).
// ---------------------------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);

    localparam int unsigned        BitCntW = $clog2(DATA_WIDTH + 1);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

    spi_state_e            r_state, w_state_next;
    logic                  r_sck, w_sck_next;
    logic                  r_keep, w_keep_next;
    logic                  r_dov, w_dov_next;
    logic [DATA_WIDTH-1:0] r_tx, w_tx_next;
    logic [DATA_WIDTH-1:0] r_rx, w_rx_next;
    logic [DATA_WIDTH-1:0] r_dout, w_dout_next;
    logic [BitCntW-1:0]    r_bit_cnt, w_bit_cnt_next;
    logic                  w_tick;
    logic                  w_restart;

    // Every state entry restarts the half-period timer.
    assign w_restart = (w_state_next != r_state);

    spi_sck_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_divider (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_sck_next     = r_sck;
        w_keep_next    = r_keep;
        w_dov_next     = 1'b0;
        w_tx_next      = r_tx;
        w_rx_next      = r_rx;
        w_dout_next    = r_dout;
        w_bit_cnt_next = r_bit_cnt;

        unique case (r_state)
            StIdle, StHold: begin
                if (bus.data_in_valid) begin
                    w_state_next = StSetup;
                    w_tx_next    = bus.data_in;
                    w_keep_next  = bus.keep_cs;
                end
            end
            StSetup: begin
                // End of setup is the first rising sck edge: sample bit 0.
                if (w_tick) begin
                    w_state_next = StXfer;
                    w_sck_next   = ~SPI_CPOL;
                    w_rx_next    = {r_rx[DATA_WIDTH-2:0], bus.miso};
                end
            end
            StXfer: begin
                if (w_tick) begin
                    if (r_sck == SPI_CPOL) begin
                        w_sck_next = ~SPI_CPOL;
                        w_rx_next  = {r_rx[DATA_WIDTH-2:0], bus.miso};
                    end else begin
                        w_sck_next = SPI_CPOL;
                        if (r_bit_cnt == LastBit) begin
                            // mosi keeps the last bit: no shift on the final fall.
                            if (r_keep) begin
                                w_state_next = StHold;
                                w_dout_next  = r_rx;
                                w_dov_next   = 1'b1;
                            end else begin
                                w_state_next = StTail;
                            end
                        end else begin
                            w_tx_next      = {r_tx[DATA_WIDTH-2:0], 1'b0};
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end
            StTail: begin
                if (w_tick) begin
                    w_state_next = StIdle;
                    w_tx_next    = '0;
                    w_dout_next  = r_rx;
                    w_dov_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        if (w_restart) begin
            w_bit_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_sck     <= SPI_CPOL;
            r_keep    <= 1'b0;
            r_dov     <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_dout    <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_sck     <= w_sck_next;
            r_keep    <= w_keep_next;
            r_dov     <= w_dov_next;
            r_tx      <= w_tx_next;
            r_rx      <= w_rx_next;
            r_dout    <= w_dout_next;
            r_bit_cnt <= w_bit_cnt_next;
        end
    end

    assign bus.sck            = r_sck;
    assign bus.cs             = (r_state == StIdle);
    assign bus.busy           = (r_state == StSetup) || (r_state == StXfer) || (r_state == StTail);
    assign bus.mosi           = r_tx[DATA_WIDTH-1];
    assign bus.data_out       = r_dout;
    assign bus.data_out_valid = r_dov;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: one CLK_DIV=4 instance (slave model or loopback on miso) and one
// CLK_DIV=1 instance in loopback. Edge/strobe events are logged with cycle stamps at negedge
// and compared against cycle numbers computed from the frame timing formulas.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    spi_master_if #(.DATA_WIDTH(8)) bus4 ();
    spi_master_if #(.DATA_WIDTH(8)) bus1 ();

    spi_master #(.CLK_DIV(4), .DATA_WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Slave model: presents its word MSB first from cs fall, next bit after each falling sck.
    logic       loop4 = 1'b0;
    logic [7:0] slave_word = 8'h00;
    logic [2:0] s_idx = 3'd0;
    assign bus4.miso = loop4 ? bus4.mosi : slave_word[3'd7 - s_idx];
    assign bus1.miso = bus1.mosi;

    int         q4_rise_cyc[$];
    logic       q4_rise_bit[$];
    int         q4_dov_cyc[$];
    logic [7:0] q4_dov_dat[$];
    int         q4_csr[$];
    int         q4_csf[$];
    int         q4_bf[$];
    int         q1_rise_cyc[$];
    logic       q1_rise_bit[$];
    int         q1_dov_cyc[$];
    logic [7:0] q1_dov_dat[$];
    logic       p_sck4, p_cs4, p_busy4, p_sck1;

    always @(negedge clk) begin
        if (bus4.sck === 1'b1 && p_sck4 === 1'b0) begin
            q4_rise_cyc.push_back(cyc);
            q4_rise_bit.push_back(bus4.mosi);
        end
        if (bus4.data_out_valid === 1'b1) begin
            q4_dov_cyc.push_back(cyc);
            q4_dov_dat.push_back(bus4.data_out);
        end
        if (bus4.cs === 1'b1 && p_cs4 === 1'b0) q4_csr.push_back(cyc);
        if (bus4.cs === 1'b0 && p_cs4 === 1'b1) q4_csf.push_back(cyc);
        if (bus4.busy === 1'b0 && p_busy4 === 1'b1) q4_bf.push_back(cyc);
        if (bus4.cs === 1'b1) s_idx <= 3'd0;
        else if (bus4.sck === 1'b0 && p_sck4 === 1'b1) s_idx <= s_idx + 3'd1;
        p_sck4  <= bus4.sck;
        p_cs4   <= bus4.cs;
        p_busy4 <= bus4.busy;
        if (bus1.sck === 1'b1 && p_sck1 === 1'b0) begin
            q1_rise_cyc.push_back(cyc);
            q1_rise_bit.push_back(bus1.mosi);
        end
        if (bus1.data_out_valid === 1'b1) begin
            q1_dov_cyc.push_back(cyc);
            q1_dov_dat.push_back(bus1.data_out);
        end
        p_sck1 <= bus1.sck;
    end

    // Reference timing: rising edge k, last fall and keep_cs=0 frame end, relative to acceptance.
    function automatic int rise_at(input int ta, input int div, input int k);
        return ta + 1 + div * (2 * k + 1);
    endfunction

    function automatic int last_fall(input int ta, input int div, input int w);
        return ta + 1 + 2 * div * w;
    endfunction

    task automatic clear_q();
        q4_rise_cyc.delete(); q4_rise_bit.delete(); q4_dov_cyc.delete(); q4_dov_dat.delete();
        q4_csr.delete(); q4_csf.delete(); q4_bf.delete();
        q1_rise_cyc.delete(); q1_rise_bit.delete(); q1_dov_cyc.delete(); q1_dov_dat.delete();
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start4(input logic [7:0] d, input logic keep, output int ta);
        bus4.data_in       = d;
        bus4.keep_cs       = keep;
        bus4.data_in_valid = 1'b1;
        ta                 = cyc;
        @(posedge clk);
        #1;
        bus4.data_in_valid = 1'b0;
    endtask

    task automatic start1(input logic [7:0] d, output int ta);
        bus1.data_in       = d;
        bus1.keep_cs       = 1'b0;
        bus1.data_in_valid = 1'b1;
        ta                 = cyc;
        @(posedge clk);
        #1;
        bus1.data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus4.cs !== 1'b1) begin bad++; $display("FAIL reset_cs: got %b want 1", bus4.cs); end
        total++; if (bus4.sck !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", bus4.sck); end
        total++; if (bus4.mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", bus4.mosi); end
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus4.busy); end
        total++; if (bus4.data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_dov: got %b want 0", bus4.data_out_valid); end
        total++; if (bus4.data_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", bus4.data_out); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus4.cs !== 1'b1 || bus1.cs !== 1'b1 || bus1.busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle: cs4/cs1/busy1=%b%b%b want 110", bus4.cs, bus1.cs, bus1.busy);
        end
    endtask

    task automatic test_single_byte();
        int         ta;
        logic [7:0] tx;
        tx = 8'hA5;
        clear_q();
        loop4 = 1'b0;
        slave_word = 8'h3C;
        start4(tx, 1'b0, ta);
        total++; if (bus4.busy !== 1'b1 || bus4.cs !== 1'b0 || bus4.mosi !== tx[7]) begin
            bad++; $display("FAIL single_cycle1: busy/cs/mosi=%b%b%b want 101", bus4.busy, bus4.cs, bus4.mosi);
        end
        goto(ta + 75);
        total++; if (q4_rise_cyc.size() != 8) begin bad++; $display("FAIL single_rises: got %0d want 8", q4_rise_cyc.size()); end
        for (int k = 0; k < 8; k++) begin
            int   c;
            logic b;
            c = (k < q4_rise_cyc.size()) ? q4_rise_cyc[k] : -1;
            b = (k < q4_rise_bit.size()) ? q4_rise_bit[k] : ~tx[7-k];
            total++; if (c != rise_at(ta, 4, k) || b !== tx[7-k]) begin
                bad++; $display("FAIL single_bit%0d: cyc %0d mosi %b want cyc %0d mosi %b", k, c - ta, b, rise_at(0, 4, k), tx[7-k]);
            end
        end
        total++; if (q4_dov_cyc.size() != 1 || q4_dov_cyc[0] != ta + 69 || q4_dov_dat[0] !== 8'h3C) begin
            bad++; $display("FAIL single_dout: %0d pulses, first cyc %0d data %h want 1 at 69 data 3c",
                            q4_dov_cyc.size(), (q4_dov_cyc.size() > 0) ? q4_dov_cyc[0] - ta : -1,
                            (q4_dov_dat.size() > 0) ? q4_dov_dat[0] : 8'hxx);
        end
        total++; if (q4_csr.size() != 1 || q4_csr[0] != ta + 69) begin
            bad++; $display("FAIL single_cs_rise: got %0d rises, first at %0d want 1 at 69", q4_csr.size(), (q4_csr.size() > 0) ? q4_csr[0] - ta : -1);
        end
        total++; if (q4_bf.size() != 1 || q4_bf[0] != ta + 69) begin
            bad++; $display("FAIL single_busy_fall: got %0d falls, first at %0d want 1 at 69", q4_bf.size(), (q4_bf.size() > 0) ? q4_bf[0] - ta : -1);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) begin
            int         ta;
            logic [7:0] tx, sw, want;
            tx = 8'($urandom_range(0, 255));
            sw = 8'($urandom_range(0, 255));
            clear_q();
            loop4 = 1'($urandom_range(0, 1));
            slave_word = sw;
            want = loop4 ? tx : sw;
            start4(tx, 1'b0, ta);
            goto(ta + 72);
            for (int k = 0; k < 8; k++) begin
                logic b;
                b = (k < q4_rise_bit.size()) ? q4_rise_bit[k] : ~tx[7-k];
                total++; if (b !== tx[7-k]) begin bad++; $display("FAIL rand%0d_bit%0d: got %b want %b", n, k, b, tx[7-k]); end
            end
            total++; if (q4_dov_cyc.size() != 1 || q4_dov_cyc[0] != last_fall(ta, 4, 8) + 4 || q4_dov_dat[0] !== want) begin
                bad++; $display("FAIL rand%0d_dout: %0d pulses data %h want 1 pulse data %h", n, q4_dov_cyc.size(),
                                (q4_dov_dat.size() > 0) ? q4_dov_dat[0] : 8'hxx, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ta, tb2;
        clear_q();
        loop4 = 1'b1;
        start4(8'hFF, 1'b0, ta);
        goto(ta + 69);
        start4(8'h00, 1'b0, tb2);
        total++; if (bus4.busy !== 1'b1 || bus4.cs !== 1'b0) begin
            bad++; $display("FAIL b2b_accept: busy/cs=%b%b want 10 one cycle after cycle 69", bus4.busy, bus4.cs);
        end
        goto(tb2 + 75);
        total++; if (q4_dov_cyc.size() != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", q4_dov_cyc.size()); end
        total++; if (q4_dov_cyc.size() < 2 || q4_dov_cyc[0] != ta + 69 || q4_dov_dat[0] !== 8'hFF) begin
            bad++; $display("FAIL b2b_first: data %h want ff at 69", (q4_dov_dat.size() > 0) ? q4_dov_dat[0] : 8'hxx);
        end
        total++; if (q4_dov_cyc.size() < 2 || q4_dov_cyc[1] != tb2 + 69 || q4_dov_dat[1] !== 8'h00) begin
            bad++; $display("FAIL b2b_second: data %h want 00 at 69", (q4_dov_dat.size() > 1) ? q4_dov_dat[1] : 8'hxx);
        end
        total++; if (q4_csr.size() < 1 || q4_csf.size() < 2 || q4_csf[1] - q4_csr[0] != 1) begin
            bad++; $display("FAIL b2b_cs_gap: cs high %0d cycles want 1",
                            (q4_csr.size() > 0 && q4_csf.size() > 1) ? q4_csf[1] - q4_csr[0] : -1);
        end
    endtask

    task automatic test_burst();
        int ta, tb2;
        clear_q();
        loop4 = 1'b1;
        start4(8'h12, 1'b1, ta);
        goto(last_fall(ta, 4, 8));
        total++; if (bus4.cs !== 1'b0 || bus4.busy !== 1'b0 || bus4.data_out_valid !== 1'b1 || bus4.data_out !== 8'h12) begin
            bad++; $display("FAIL burst_hold: cs/busy/dov=%b%b%b dout %h want 001 12", bus4.cs, bus4.busy,
                            bus4.data_out_valid, bus4.data_out);
        end
        start4(8'h34, 1'b0, tb2);
        goto(tb2 + 75);
        total++; if (q4_csr.size() != 1 || q4_csr[0] != last_fall(tb2, 4, 8) + 4) begin
            bad++; $display("FAIL burst_cs: %0d cs rises, first at %0d want 1 at %0d", q4_csr.size(),
                            (q4_csr.size() > 0) ? q4_csr[0] - tb2 : -1, last_fall(0, 4, 8) + 4);
        end
        total++; if (q4_dov_cyc.size() != 2 || q4_dov_dat[1] !== 8'h34) begin
            bad++; $display("FAIL burst_pulses: got %0d last %h want 2 last 34", q4_dov_cyc.size(),
                            (q4_dov_dat.size() > 1) ? q4_dov_dat[1] : 8'hxx);
        end
    endtask

    task automatic test_ignored_request();
        int         ta, tx2;
        logic [7:0] tx;
        tx = 8'hA5;
        clear_q();
        loop4 = 1'b0;
        slave_word = 8'h3C;
        start4(tx, 1'b0, ta);
        goto(ta + 20);
        start4(8'h77, 1'b0, tx2);
        goto(ta + 75);
        for (int k = 0; k < 8; k++) begin
            logic b;
            b = (k < q4_rise_bit.size()) ? q4_rise_bit[k] : ~tx[7-k];
            total++; if (b !== tx[7-k]) begin bad++; $display("FAIL ignore_bit%0d: got %b want %b", k, b, tx[7-k]); end
        end
        total++; if (q4_rise_cyc.size() != 8) begin bad++; $display("FAIL ignore_rises: got %0d want 8", q4_rise_cyc.size()); end
        total++; if (q4_bf.size() != 1 || q4_bf[0] != ta + 69) begin
            bad++; $display("FAIL ignore_busy: %0d falls, first at %0d want 1 at 69", q4_bf.size(), (q4_bf.size() > 0) ? q4_bf[0] - ta : -1);
        end
        total++; if (q4_dov_dat.size() != 1 || q4_dov_dat[0] !== 8'h3C) begin
            bad++; $display("FAIL ignore_dout: %0d pulses want 1 with 3c", q4_dov_dat.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int ta;
        clear_q();
        loop4 = 1'b0;
        slave_word = 8'h3C;
        start4(8'hA5, 1'b0, ta);
        goto(ta + 30);
        rst = 1'b1;
        #1;
        total++; if (bus4.cs !== 1'b1 || bus4.sck !== 1'b0 || bus4.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_pins: cs/sck/busy=%b%b%b want 100", bus4.cs, bus4.sck, bus4.busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        goto(ta + 80);
        total++; if (q4_dov_cyc.size() != 0) begin bad++; $display("FAIL midrst_dov: got %0d pulses want 0", q4_dov_cyc.size()); end
        test_single_byte();
    endtask

    task automatic test_div1();
        for (int n = 0; n < 3; n++) begin
            int         ta;
            logic [7:0] tx;
            tx = (n == 0) ? 8'hC3 : 8'($urandom_range(0, 255));
            clear_q();
            start1(tx, ta);
            goto(ta + 24);
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (k < q1_rise_cyc.size()) ? q1_rise_cyc[k] : -1;
                total++; if (c != rise_at(ta, 1, k)) begin
                    bad++; $display("FAIL div1_%0d_rise%0d: at %0d want %0d", n, k, c - ta, rise_at(0, 1, k));
                end
            end
            total++; if (q1_dov_cyc.size() != 1 || q1_dov_cyc[0] != ta + 18 || q1_dov_dat[0] !== tx) begin
                bad++; $display("FAIL div1_%0d_dout: %0d pulses data %h want 1 at 18 data %h", n, q1_dov_cyc.size(),
                                (q1_dov_dat.size() > 0) ? q1_dov_dat[0] : 8'hxx, tx);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus4.data_in = 8'h00; bus4.data_in_valid = 1'b0; bus4.keep_cs = 1'b0;
        bus1.data_in = 8'h00; bus1.data_in_valid = 1'b0; bus1.keep_cs = 1'b0;
        test_reset();
        test_single_byte();
        test_random_frames();
        test_back_to_back();
        test_burst();
        test_ignored_request();
        test_reset_mid_frame();
        test_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI mode-0 master that drives the sck/cs/mosi pins and samples miso, one DATA_WIDTH-bit frame per accepted request. It is the initiator counterpart of the SPI_Slave core and exists to exercise that core board-to-board or in loopback. It can also drive external SPI peripherals from FPGA logic. The user side uses the same valid/busy handshake style as SPI_Slave: data_in_valid, busy and data_out_valid.

## Interface
Parameters:
- CLK_DIV, 4: sck half-period in clk cycles; legal range ≥1.
- DATA_WIDTH, 8: bits per frame, MSB first.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  DATA_WIDTH  word to transmit; sampled when a request is accepted.
- data_in_valid  in  1  request pulse; accepted only in IDLE or HOLD.
- keep_cs  in  1  sampled with data_in_valid; 1 keeps cs low after the frame (burst).
- data_out  out  DATA_WIDTH  word received on miso; stable until the next frame completes.
- data_out_valid  out  1  one-cycle pulse when data_out updates.
- busy  out  1  high from acceptance until frame completion.
- sck  out  1  SPI clock; idles low (CPOL=0).
- cs  out  1  chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

## Operation
- Mode 0: mosi changes on falling sck (and at cs fall); miso is sampled at rising sck.
- States:
  - IDLE: cs=1, sck=0, busy=0.
  - SETUP: CLK_DIV cycles with cs=0 and mosi=MSB.
  - XFER: DATA_WIDTH sck periods.
  - TAIL: CLK_DIV cycles with sck=0 and cs=0.
  - HOLD: cs=0, sck=0, busy=0, waiting for the next word.
- Transitions:
  - IDLE --valid--> SETUP.
  - SETUP --count done--> XFER.
  - XFER --last fall, keep_cs=0--> TAIL.
  - XFER --last fall, keep_cs=1--> HOLD.
  - TAIL --count done--> IDLE.
  - HOLD --valid--> SETUP.
- Datapath:
  - Shift register loaded with data_in on acceptance.
  - miso is shifted into the LSB in the cycle sck goes 0→1.
  - The TX shift advances on each falling edge except the last.
  - miso is used directly, with no synchronizer.
- data_in_valid while busy=1 is ignored: no queue, no error flag.
- keep_cs is latched per frame. A burst ends by sending a word with keep_cs=0.
- Counters:
  - Divider counts 0..CLK_DIV-1.
  - Bit counter is $clog2(DATA_WIDTH+1) wide.
  - Both clear on rst and on every state entry.

## Timing
- Reset values: cs=1, sck=0, mosi=0, busy=0, data_out_valid=0, data_out=0, state IDLE.
- Reset asserted mid-frame: outputs take reset values immediately (asynchronous). The partial frame is discarded and data_out_valid is not pulsed.
- Request accepted at cycle 0 (from IDLE or HOLD). At cycle 1: busy=1, cs=0, mosi=data_in[DATA_WIDTH-1].
- Rising edge k (k=0..DATA_WIDTH-1) occurs at cycle 1+CLK_DIV·(2k+1). Falling edge k occurs at cycle 1+CLK_DIV·(2k+2).
- Last falling edge falls at cycle F=1+2·CLK_DIV·DATA_WIDTH.
- keep_cs=0 frame end:
  - cs=1, busy=0 and data_out_valid=1 all at cycle F+CLK_DIV.
  - Example, CLK_DIV=4, DATA_WIDTH=8: cycle 69.
  - A new request is accepted in that same cycle.
- keep_cs=1 frame end:
  - At cycle F: state HOLD, busy=0, data_out_valid=1, cs stays 0.
  - A request is accepted at F or any later cycle.
- mosi holds its last bit through TAIL and HOLD. It returns to 0 in IDLE.

## Structure
- Shared package spi_pkg holds:
  - state enum (IDLE, SETUP, XFER, TAIL, HOLD);
  - CPOL/CPHA constants (0/0);
  - default width constant SPI_DATA_WIDTH=8.
- Sub-module spi_sck_divider:
  - Divider counter with a "half-period tick" output; cleared by a restart input.
  - The main FSM consumes the tick.

## Test plan
- Single byte, CLK_DIV=4, data_in=0xA5, miso driven from a slave model returning 0x3C:
  - mosi bit sequence 1,0,1,0,0,1,0,1 at rising edges;
  - data_out=0x3C with data_out_valid at cycle 69;
  - cs high at cycle 69.
- Loopback miso=mosi, data_in=0xFF then 0x00 back-to-back:
  - second request accepted in cycle 69 of the first frame;
  - data_out 0xFF then 0x00;
  - cs high for exactly 1 cycle between frames.
- Burst, keep_cs=1 with 0x12 then keep_cs=0 with 0x34:
  - cs never rises between words;
  - two data_out_valid pulses;
  - cs rises CLK_DIV cycles after the second word's final fall.
- data_in_valid pulsed with 0x77 at cycle 20 of a 0xA5 frame:
  - ignored; only 0xA5 appears on mosi;
  - busy stays high until cycle 69.
- rst asserted at cycle 30 of a frame:
  - cs=1, sck=0, busy=0 within the same cycle;
  - no data_out_valid;
  - next frame after release behaves as the first test.
- CLK_DIV=1, data_in=0xC3, loopback: sck period of 2 cycles, data_out=0xC3 at cycle 18.
